// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Existing 4-bit ripple-carry adder; sum carries the carry-out as its top bit as well.
module ripple_carry_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W:0]   sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign sum[NIBBLE_W] = c[NIBBLE_W];
    assign cout          = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit adder walks the operands LSB nibble first,
// with the registered carry fed back between nibbles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e state_q, state_d;

    logic [NIB-1:0][NIBBLE_W-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         carry_q;
    logic                         cout_q;

    logic [NIBBLE_W:0]            add_sum;
    logic                         add_cout;
    logic                         accept;
    logic                         last;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign accept = ready && start;
    assign last   = (idx_q == LAST);
    assign sum    = sum_q;
    assign cout   = cout_q;

    ripple_carry_adder u_rca (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The adder's top sum bit is a copy of its carry-out; only cout is consumed.
    always_comb begin
        assert (add_sum[NIBBLE_W] == add_cout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // cout is captured on the final nibble so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= cin;
            cout_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            sum_q[idx_q] <= add_sum[NIBBLE_W-1:0];
            carry_q      <= add_cout;
            idx_q        <= idx_q + 1'b1;
            if (last) cout_q <= add_cout;
        end
    end

endmodule
